// File: rtl/bsram_fifo_ctrl_pkg.sv
// Shared constants for the BSRAM-backed FIFO controller: the primitive's port widths
// and the depth of the output buffer that absorbs the BSRAM read latency.
package bsram_fifo_ctrl_pkg;

    localparam int BSRAM_ADDR_W = 14;
    localparam int BSRAM_DATA_W = 18;

    // Two spare slots beyond the read pipeline let issue run back-to-back while the consumer pops.
    function automatic int out_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular output buffer that receives words returning from the BSRAM read
// pipeline and presents the head entry to the consumer.
module fifo_skid_buf #(
    parameter int  DATA_W    = 18,
    parameter int  OUT_DEPTH = 4,
    localparam int CNT_W     = $clog2(OUT_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push  = push_i && (cnt_q != CNT_W'(OUT_DEPTH));
        do_pop   = pop_i && (cnt_q != '0);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // The issue-side credit check must make a returning word into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (cnt_q == CNT_W'(OUT_DEPTH))));

endmodule

// File: rtl/bsram_fifo_ctrl.sv
// Single-clock FIFO controller over an external dual-port BSRAM: port A writes, port B
// reads ahead into a small output buffer sized to hide the BSRAM read latency.
module bsram_fifo_ctrl
    import bsram_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DATA_W     = 18,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [DATA_W-1:0]       wr_data_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [BSRAM_ADDR_W-1:0] bram_ada_o,
    output logic [BSRAM_DATA_W-1:0] bram_dia_o,
    output logic                    bram_wrea_o,
    output logic                    bram_cea_o,
    output logic                    bram_ocea_o,
    output logic [BSRAM_ADDR_W-1:0] bram_adb_o,
    output logic                    bram_ceb_o,
    output logic                    bram_oceb_o,
    output logic                    bram_wreb_o,
    input  logic [BSRAM_DATA_W-1:0] bram_dob_i,
    output logic                    bram_reset_o
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int OUT_DEPTH = out_depth(RD_LATENCY);
    localparam int TAG_LEN   = RD_LATENCY + 1;
    localparam int IF_W      = $clog2(TAG_LEN + 1);
    localparam int OCNT_W    = $clog2(OUT_DEPTH + 1);
    localparam int CRED_W    = OCNT_W + IF_W + 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
    logic [TAG_LEN-1:0] tag_q, tag_d;
    logic [IF_W-1:0]    inflight;
    logic [OCNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]   total;
    logic               full_int;
    logic               wr_fire, issue, capture, pop;
    logic               buf_valid;
    logic [DATA_W-1:0]  buf_data;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < TAG_LEN; i++) begin
            inflight = inflight + IF_W'(tag_q[i]);
        end
    end

    // Full counts every word held anywhere, so count_o never exceeds DEPTH.
    assign total      = mem_cnt_q + CNT_W'(inflight) + CNT_W'(out_cnt);
    assign full_int   = (total == CNT_W'(DEPTH));
    assign wr_ready_o = !rst_i && !full_int;
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign pop        = rd_valid_o && rd_ready_i;

    // A pop this cycle frees one slot before any newly issued word can return.
    assign issue = !rst_i && (mem_cnt_q != '0) &&
                   ((CRED_W'(out_cnt) + CRED_W'(inflight)) < (CRED_W'(OUT_DEPTH) + CRED_W'(pop)));
    assign capture = !rst_i && tag_q[TAG_LEN-1];

    always_comb begin
        wr_ptr_d  = wr_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = issue ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + CNT_W'(wr_fire) - CNT_W'(issue);
        tag_d     = {tag_q[TAG_LEN-2:0], issue};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            tag_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            tag_q     <= tag_d;
        end
    end

    fifo_skid_buf #(
        .DATA_W    (DATA_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (capture),
        .push_data_i (bram_dob_i[DATA_W-1:0]),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .count_o     (out_cnt)
    );

    assign rd_valid_o   = !rst_i && buf_valid;
    assign rd_data_o    = rd_valid_o ? buf_data : '0;
    assign count_o      = rst_i ? '0 : total;
    assign full_o       = !rst_i && full_int;
    assign empty_o      = rst_i || (total == '0);

    assign bram_ada_o   = BSRAM_ADDR_W'(wr_ptr_q);
    assign bram_dia_o   = BSRAM_DATA_W'(wr_data_i);
    assign bram_wrea_o  = wr_fire;
    assign bram_cea_o   = !rst_i;
    assign bram_ocea_o  = 1'b0;
    assign bram_adb_o   = BSRAM_ADDR_W'(rd_ptr_q);
    assign bram_ceb_o   = issue;
    assign bram_oceb_o  = issue;
    assign bram_wreb_o  = 1'b0;
    assign bram_reset_o = rst_i;

endmodule
